// File: rtl/cache_exerciser.sv
// Cache test engine: writes an address-derived pattern over a strided word range,
// reads it back, and counts mismatches against the same pattern.
module cache_exerciser #(
  parameter logic [31:0] START_ADDRESS = 32'h0000_0000,
  parameter int unsigned ADDR_STEP     = 4,
  parameter int unsigned WORD_COUNT    = 16,
  parameter logic [31:0] PATTERN_SEED  = 32'hA5A5_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        br_busy,
  output logic [31:0] address,
  output logic [31:0] data_in,
  output logic [3:0]  write_enable,
  input  logic [31:0] data_out,
  input  logic        data_out_ready,
  input  logic        busy,
  output logic        active,
  output logic        done,
  output logic        pass,
  output logic [15:0] error_count,
  output logic [31:0] fail_address
);

  typedef enum logic [2:0] {
    IDLE, WAIT_INIT, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, FINISH
  } state_t;

  localparam logic [31:0] STEP     = 32'(ADDR_STEP);
  localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);

  state_t      state;
  logic        do_write;
  logic        do_read;
  logic [15:0] word_idx;

  logic        last_word;
  logic [31:0] next_address;
  logic        mismatch;

  assign last_word    = (word_idx == LAST_IDX);
  assign next_address = address + STEP;
  assign mismatch     = (data_out != (address ^ PATTERN_SEED));

  // NOTE: all state and outputs are assigned with <= so every read in this block
  // sees the value from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      do_write     <= 1'b0;
      do_read      <= 1'b0;
      word_idx     <= '0;
      address      <= START_ADDRESS;
      data_in      <= '0;
      write_enable <= '0;
      active       <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      error_count  <= '0;
      fail_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= WAIT_INIT;
            do_write     <= (mode != 2'd1);
            do_read      <= (mode != 2'd0);
            word_idx     <= '0;
            address      <= START_ADDRESS;
            error_count  <= '0;
            fail_address <= '0;
            pass         <= 1'b0;
            active       <= 1'b1;
          end
        end

        WAIT_INIT: begin
          if (!br_busy && !busy) begin
            if (do_write) begin
              state        <= WR_ISSUE;
              write_enable <= 4'b1111;
              data_in      <= address ^ PATTERN_SEED;
            end else begin
              state <= RD_ISSUE;
            end
          end
        end

        WR_ISSUE: begin
          write_enable <= 4'b0000;
          state        <= WR_WAIT;
        end

        WR_WAIT: begin
          if (!busy) begin
            if (!last_word) begin
              // Next write is issued straight away with its pattern precomputed.
              word_idx     <= word_idx + 16'd1;
              address      <= next_address;
              data_in      <= next_address ^ PATTERN_SEED;
              write_enable <= 4'b1111;
              state        <= WR_ISSUE;
            end else if (do_read) begin
              word_idx <= '0;
              address  <= START_ADDRESS;
              state    <= RD_ISSUE;
            end else begin
              done  <= 1'b1;
              pass  <= 1'b1;
              state <= FINISH;
            end
          end
        end

        RD_ISSUE: state <= RD_WAIT;

        RD_WAIT: begin
          if (data_out_ready && !busy) begin
            if (mismatch) begin
              if (error_count == 16'd0) fail_address <= address;
              if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
            end
            if (last_word) begin
              // Fold in this final comparison so pass is valid alongside done.
              done  <= 1'b1;
              pass  <= (error_count == 16'd0) && !mismatch;
              state <= FINISH;
            end else begin
              word_idx <= word_idx + 16'd1;
              address  <= next_address;
              state    <= RD_ISSUE;
            end
          end
        end

        FINISH: begin
          done   <= 1'b0;
          active <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
